// File: rtl/dsp_flow_ctrl_pkg.sv
// ============================================================================
// dsp_flow_ctrl_pkg : state encoding and default sizing for dsp_flow_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package dsp_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INIT    = 2'd1,
    ST_PREFILL = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_PREFILL_CYCLES = 16;
  localparam int unsigned DEFAULT_CNT_WIDTH      = 16;
  // Wide enough for any prefill length up to 65535 cycles.
  localparam int unsigned PF_CNT_W               = 16;

endpackage : dsp_flow_ctrl_pkg

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : saturating event counter with synchronous clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

`default_nettype wire

// File: rtl/dsp_flow_ctrl.sv
// ============================================================================
// dsp_flow_ctrl : ADC->DSP->DAC streaming sequencer with FIFO prefill and
//                 overflow/underflow event counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module dsp_flow_ctrl
  import dsp_flow_ctrl_pkg::*;
#(
  parameter int unsigned PREFILL_CYCLES = DEFAULT_PREFILL_CYCLES,
  parameter int unsigned CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_req,
  input  logic                 infifo_almst_empty,
  input  logic                 infifo_almst_full,
  input  logic                 infifo_rst_busy,
  input  logic                 outfifo_almst_full,
  input  logic                 outfifo_almst_empty,
  output logic                 dsp_en,
  output logic                 outrd_en,
  output logic [1:0]           state,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  output logic [CNT_WIDTH-1:0] unf_cnt
);

  localparam logic [PF_CNT_W-1:0] PF_LAST = PF_CNT_W'(PREFILL_CYCLES - 1);

  state_e              state_q,   state_d;
  logic [PF_CNT_W-1:0] prefill_q, prefill_d;
  logic                dsp_en_q,  dsp_en_d;
  logic                outrd_q,   outrd_d;
  logic                cnt_clr;
  logic                ovf_inc;
  logic                unf_inc;

  // run_req=0 outranks everything; rst_busy outranks prefill progress.
  always_comb begin
    state_d   = state_q;
    prefill_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (run_req) state_d = ST_INIT;
      end
      ST_INIT: begin
        if (!run_req)              state_d = ST_IDLE;
        else if (!infifo_rst_busy) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (!run_req) begin
          state_d = ST_IDLE;
        end else if (infifo_rst_busy) begin
          state_d = ST_INIT;
        end else if (!infifo_almst_empty) begin
          if (prefill_q == PF_LAST) state_d = ST_RUN;
          else                      prefill_d = prefill_q + PF_CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!run_req)             state_d = ST_IDLE;
        else if (infifo_rst_busy) state_d = ST_INIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Enables look at the next state so they drop on the same edge RUN is left.
  always_comb begin
    dsp_en_d = (state_d == ST_RUN) && !infifo_almst_empty &&
               !outfifo_almst_full && !infifo_rst_busy;
    outrd_d  = (state_d == ST_RUN) && !outfifo_almst_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      prefill_q <= '0;
      dsp_en_q  <= 1'b0;
      outrd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      prefill_q <= prefill_d;
      dsp_en_q  <= dsp_en_d;
      outrd_q   <= outrd_d;
    end
  end

  assign cnt_clr = (state_q == ST_IDLE) && run_req;
  assign ovf_inc = (state_q == ST_RUN) && infifo_almst_full;
  assign unf_inc = (state_q == ST_RUN) && outfifo_almst_empty;

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_ovf_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (ovf_inc),
    .count (ovf_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_unf_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (unf_inc),
    .count (unf_cnt)
  );

  assign dsp_en   = dsp_en_q;
  assign outrd_en = outrd_q;
  assign state    = state_q;
  assign running  = (state_q == ST_RUN);

endmodule : dsp_flow_ctrl

`default_nettype wire

// File: tb/tb_dsp_flow_ctrl.sv
// ============================================================================
// tb_dsp_flow_ctrl : directed self-checking bench for dsp_flow_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dsp_flow_ctrl;
  import dsp_flow_ctrl_pkg::*;

  localparam int unsigned PF = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          run_req;
  logic          in_ae;
  logic          in_af;
  logic          in_busy;
  logic          out_af;
  logic          out_ae;
  logic          dsp_en;
  logic          outrd_en;
  logic [1:0]    state;
  logic          running;
  logic [CW-1:0] ovf_cnt;
  logic [CW-1:0] unf_cnt;

  int vectors    = 0;
  int miscompares = 0;

  dsp_flow_ctrl #(
    .PREFILL_CYCLES (PF),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .run_req             (run_req),
    .infifo_almst_empty  (in_ae),
    .infifo_almst_full   (in_af),
    .infifo_rst_busy     (in_busy),
    .outfifo_almst_full  (out_af),
    .outfifo_almst_empty (out_ae),
    .dsp_en              (dsp_en),
    .outrd_en            (outrd_en),
    .state               (state),
    .running             (running),
    .ovf_cnt             (ovf_cnt),
    .unf_cnt             (unf_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},   32'(state),    32'(ST_IDLE));
    chk({tag, "_running"}, 32'(running),  32'd0);
    chk({tag, "_dsp_en"},  32'(dsp_en),   32'd0);
    chk({tag, "_outrd"},   32'(outrd_en), 32'd0);
    chk({tag, "_ovf"},     32'(ovf_cnt),  32'd0);
    chk({tag, "_unf"},     32'(unf_cnt),  32'd0);
  endtask

  // From PREFILL entry (count 0) with in_ae=0: 15 PREFILL edges, RUN on the 16th.
  task automatic prefill_to_run(input string tag);
    for (int i = 0; i < int'(PF) - 1; i++) begin
      step();
      chk({tag, "_pf"}, 32'(state), 32'(ST_PREFILL));
    end
    step();
    chk({tag, "_run"}, 32'(state), 32'(ST_RUN));
  endtask

  initial begin
    rst = 1'b1; run_req = 1'b0; in_ae = 1'b1; in_af = 1'b0;
    in_busy = 1'b1; out_af = 1'b0; out_ae = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_reset_outputs("reset");

    // Startup: busy held for 5 sampled cycles -> 5 cycles of INIT.
    rst = 1'b0; run_req = 1'b1; in_ae = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("start_init", 32'(state), 32'(ST_INIT));
    end
    in_busy = 1'b0;
    step();
    chk("start_pf0", 32'(state), 32'(ST_PREFILL));
    prefill_to_run("start");
    chk("start_running", 32'(running), 32'd1);
    step();
    chk("start_dsp_en", 32'(dsp_en),   32'd1);
    chk("start_outrd",  32'(outrd_en), 32'd1);

    // Backpressure: dsp_en low for exactly the 4 cycles, one cycle late.
    out_af = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_dsp_low",  32'(dsp_en),   32'd0);
      chk("bp_outrd_on", 32'(outrd_en), 32'd1);
    end
    out_af = 1'b0;
    step();
    chk("bp_dsp_back", 32'(dsp_en), 32'd1);

    // Overflow counter saturates at 15 over 20 RUN cycles.
    in_af = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("sat_ovf", 32'(ovf_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    in_af = 1'b0;
    step();
    chk("sat_hold", 32'(ovf_cnt), 32'd15);
    chk("sat_unf0", 32'(unf_cnt), 32'd0);

    // Both events in one cycle increment both counters.
    in_af = 1'b1; out_ae = 1'b1;
    step();
    chk("both_ovf", 32'(ovf_cnt), 32'd15);
    chk("both_unf", 32'(unf_cnt), 32'd1);
    chk("both_outrd", 32'(outrd_en), 32'd0);
    in_af = 1'b0; out_ae = 1'b0;
    step();
    chk("both_unf_hold", 32'(unf_cnt), 32'd1);

    // Leave RUN: enables drop at once, counters held in IDLE, cleared on re-request.
    run_req = 1'b0;
    step();
    chk("stop_state", 32'(state),    32'(ST_IDLE));
    chk("stop_dsp",   32'(dsp_en),   32'd0);
    chk("stop_outrd", 32'(outrd_en), 32'd0);
    chk("stop_ovf",   32'(ovf_cnt),  32'd15);
    step();
    chk("idle_ovf_hold", 32'(ovf_cnt), 32'd15);
    run_req = 1'b1;
    step();
    chk("rereq_state", 32'(state),   32'(ST_INIT));
    chk("rereq_ovf",   32'(ovf_cnt), 32'd0);
    chk("rereq_unf",   32'(unf_cnt), 32'd0);

    // Prefill restart: almost-empty pulse at count 10 restarts the count.
    step();
    chk("pr_pf0", 32'(state), 32'(ST_PREFILL));
    for (int i = 0; i < 10; i++) step();
    chk("pr_pf10", 32'(state), 32'(ST_PREFILL));
    in_ae = 1'b1;
    step();
    chk("pr_pulse", 32'(state), 32'(ST_PREFILL));
    in_ae = 1'b0;
    prefill_to_run("pr");
    step();
    chk("pr_dsp_en", 32'(dsp_en), 32'd1);

    // Mid-RUN FIFO reset: back to INIT, enables drop.
    in_busy = 1'b1;
    step();
    chk("busy_state", 32'(state),  32'(ST_INIT));
    chk("busy_dsp",   32'(dsp_en), 32'd0);
    step();
    chk("busy_dsp2",  32'(dsp_en), 32'd0);
    in_busy = 1'b0;
    step();
    chk("busy_pf", 32'(state), 32'(ST_PREFILL));
    prefill_to_run("busy");

    // rst_busy and run_req=0 together: IDLE wins.
    in_busy = 1'b1; run_req = 1'b0;
    step();
    chk("both_stop_state", 32'(state), 32'(ST_IDLE));
    in_busy = 1'b0; run_req = 1'b1;
    step();
    chk("restart_init", 32'(state), 32'(ST_INIT));
    step();
    chk("restart_pf", 32'(state), 32'(ST_PREFILL));
    prefill_to_run("restart");
    out_ae = 1'b1;
    step();
    step();
    out_ae = 1'b0;
    step();
    chk("pre_rst_unf", 32'(unf_cnt), 32'd2);
    chk("pre_rst_dsp", 32'(dsp_en),  32'd1);

    // Reset mid-RUN beats run_req, then IDLE until run_req is sampled high.
    rst = 1'b1;
    step();
    chk_reset_outputs("midrst");
    rst = 1'b0; run_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_idle", 32'(state), 32'(ST_IDLE));
    end
    run_req = 1'b1;
    step();
    chk("postrst_init", 32'(state), 32'(ST_INIT));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_dsp_flow_ctrl

`default_nettype wire

// File: doc/dsp_flow_ctrl.md
DSP_FLOW_CTRL -- requirements
Module: dsp_flow_ctrl

Interface
REQ-001 The block SHALL have parameter PREFILL_CYCLES, default 16: consecutive cycles with input FIFO not almost-empty before streaming starts (valid range 1..65535).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16: width of the event counters.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; the only clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port run_req, input, 1 bit: level request to stream ADC->DSP->DAC.
REQ-006 The block SHALL have port infifo_almst_empty, input, 1 bit: input FIFO almost-empty flag.
REQ-007 The block SHALL have port infifo_almst_full, input, 1 bit: input FIFO almost-full flag.
REQ-008 The block SHALL have port infifo_rst_busy, input, 1 bit: input FIFO read-side reset busy.
REQ-009 The block SHALL have port outfifo_almst_full, input, 1 bit: output FIFO almost-full flag.
REQ-010 The block SHALL have port outfifo_almst_empty, input, 1 bit: output FIFO almost-empty flag.
REQ-011 The block SHALL have port dsp_en, output, 1 bit: input FIFO rd_en, output FIFO wr_en and Costas loop enable.
REQ-012 The block SHALL have port outrd_en, output, 1 bit: output FIFO rd_en toward the DAC path.
REQ-013 The block SHALL have port state, output, 2 bits: current FSM state.
REQ-014 The block SHALL have port running, output, 1 bit: high exactly when state is RUN.
REQ-015 The block SHALL have port ovf_cnt, output, CNT_WIDTH bits: saturating count of RUN cycles with infifo_almst_full=1.
REQ-016 The block SHALL have port unf_cnt, output, CNT_WIDTH bits: saturating count of RUN cycles with outfifo_almst_empty=1.

Function
REQ-017 The FSM SHALL have states IDLE=0, INIT=1, PREFILL=2 and RUN=3, all registered on clk.
REQ-018 In IDLE, run_req=1 SHALL move the FSM to INIT on the next edge and clear both counters on that same edge.
REQ-019 In INIT, infifo_rst_busy=0 SHALL move the FSM to PREFILL; otherwise it SHALL remain in INIT.
REQ-020 PREFILL SHALL use a prefill counter that increments on each cycle with infifo_almst_empty=0 and clears to 0 on any cycle with infifo_almst_empty=1.
REQ-021 When the prefill counter equals PREFILL_CYCLES-1 and infifo_almst_empty=0, the FSM SHALL move to RUN on that edge.
REQ-022 The prefill counter SHALL be 0 on every entry to PREFILL.
REQ-023 In any non-IDLE state, run_req=0 SHALL move the FSM to IDLE on the next edge, taking priority over all other transitions.
REQ-024 In PREFILL or RUN, infifo_rst_busy=1 SHALL move the FSM to INIT unless run_req=0, in which case it SHALL move to IDLE.
REQ-025 dsp_en SHALL be registered and equal, one cycle late, to (next state is RUN) AND !infifo_almst_empty AND !outfifo_almst_full AND !infifo_rst_busy.
REQ-026 outrd_en SHALL be registered and equal, one cycle late, to (next state is RUN) AND !outfifo_almst_empty.
REQ-027 dsp_en and outrd_en SHALL be 0 in the first cycle after any exit from RUN.
REQ-028 In RUN, ovf_cnt SHALL increment by 1 on each cycle with infifo_almst_full=1, and unf_cnt SHALL increment by 1 on each cycle with outfifo_almst_empty=1.
REQ-029 ovf_cnt and unf_cnt SHALL saturate at 2^CNT_WIDTH-1 without wrapping.
REQ-030 ovf_cnt and unf_cnt SHALL hold their values outside RUN, except when cleared per REQ-018.
REQ-031 If infifo_almst_full and outfifo_almst_empty are both 1 in the same RUN cycle, both counters SHALL increment on that cycle.

Reset
REQ-032 While rst=1 on an edge, the block SHALL set state=IDLE, running=0, dsp_en=0, outrd_en=0, ovf_cnt=0, unf_cnt=0 and prefill counter=0.
REQ-033 rst SHALL take priority over every other input, including mid-RUN.
REQ-034 After rst deasserts, the block SHALL remain in IDLE until run_req=1 is sampled.

Structure
REQ-035 A shared package SHALL hold the state encoding constants (IDLE/INIT/PREFILL/RUN) and the default PREFILL_CYCLES and CNT_WIDTH values.
REQ-036 The block SHALL instantiate sub-module sat_counter (parameter WIDTH; ports clk, rst, clr, inc, count) twice, once each for ovf_cnt and unf_cnt.

Verification
REQ-037 Bench SHALL cover startup: rst 3 cycles, then run_req=1, infifo_rst_busy=1 for 5 cycles, then 0, with infifo_almst_empty=0 -> INIT for 5 cycles, PREFILL for 16 cycles, RUN entered, dsp_en=1 one cycle after entering RUN.
REQ-038 Bench SHALL cover prefill restart: infifo_almst_empty pulses 1 at prefill count 10 -> count clears, RUN reached 16 cycles after the pulse ends.
REQ-039 Bench SHALL cover backpressure: in RUN, outfifo_almst_full=1 for 4 cycles -> dsp_en=0 for exactly those 4 cycles shifted by one, with outrd_en unaffected.
REQ-040 Bench SHALL cover counter saturation with CNT_WIDTH=4: infifo_almst_full=1 for 20 RUN cycles -> ovf_cnt=15 and held; then run_req 0->1 -> ovf_cnt=0.
REQ-041 Bench SHALL cover mid-RUN events: infifo_rst_busy=1 -> state=INIT next edge, dsp_en=0 the cycle after; run_req=0 on the same cycle -> IDLE instead.
REQ-042 Bench SHALL cover reset mid-RUN: rst=1 for 1 cycle with dsp_en=1 -> all outputs at reset values on the next edge, and the block stays in IDLE until run_req is re-sampled as 1.
